// File: rtl/rr_arbiter_fsm.sv
// Four-requester round-robin arbiter with a per-owner hold limit.
// Every grant ends in a one-cycle gap before the next arbitration.
module rr_arbiter_fsm #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       expired,
    output logic [1:0] state_dbg
);

    // Handshake: req is level-sensitive and has no ready; the owner keeps its
    // grant while req[gnt_id] stays high, until the hold limit revokes it.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t        state, state_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [3:0]    gnt_nxt;
    logic [1:0]    gnt_id_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          expired_nxt;
    logic [1:0]    win;

    // Descending scan so the smallest offset from p is the last to overwrite.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            gnt      <= 4'd0;
            gnt_id   <= 2'd0;
            hold_cnt <= '0;
            expired  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            hold_cnt <= hold_nxt;
            expired  <= expired_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gnt_nxt     = gnt;
        gnt_id_nxt  = gnt_id;
        hold_nxt    = hold_cnt;
        expired_nxt = 1'b0;
        win         = rr_pick(req, ptr);
        case (state)
            IDLE, GAP: begin
                if (|req) begin
                    state_nxt  = GRANT;
                    gnt_nxt    = 4'b0001 << win;
                    gnt_id_nxt = win;
                    hold_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'd0;
                end
            end
            GRANT: begin
                // A release on the limit cycle wins over expiry.
                if (!req[gnt_id]) begin
                    state_nxt = GAP;
                    gnt_nxt   = 4'd0;
                    ptr_nxt   = gnt_id + 2'd1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt   = GAP;
                    gnt_nxt     = 4'd0;
                    ptr_nxt     = gnt_id + 2'd1;
                    expired_nxt = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'd0;
            end
        endcase
    end

    assign busy      = (state == GRANT);
    assign state_dbg = state;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Bench for rr_arbiter_fsm: instance a uses MAX_HOLD=4, instance b MAX_HOLD=1,
// both compared every cycle against a cycle-count reference model.
module tb_rr_arbiter_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] gnt_id_a, gnt_id_b;
    logic       busy_a, busy_b, expired_a, expired_b;
    logic [1:0] state_a, state_b;

    rr_arbiter_fsm #(.MAX_HOLD(4)) dut_a (
        .clk(clk), .reset(reset_a), .req(req_a), .gnt(gnt_a), .gnt_id(gnt_id_a),
        .busy(busy_a), .expired(expired_a), .state_dbg(state_a)
    );

    rr_arbiter_fsm #(.MAX_HOLD(1)) dut_b (
        .clk(clk), .reset(reset_b), .req(req_b), .gnt(gnt_b), .gnt_id(gnt_id_b),
        .busy(busy_b), .expired(expired_b), .state_dbg(state_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    // Reference model: owner -1 means nobody holds; held counts granted cycles.
    int m_owner[2];
    int m_last[2];
    int m_ptr[2];
    int m_held[2];
    int m_exp[2];
    int m_limit[2] = '{4, 1};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] r, input logic rst);
        int found;
        if (rst) begin
            m_owner[k] = -1; m_last[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_exp[k] = 0;
        end else if (m_owner[k] >= 0) begin
            if (!r[m_owner[k]] || m_held[k] == m_limit[k]) begin
                m_exp[k]   = r[m_owner[k]] ? 1 : 0;
                m_ptr[k]   = (m_owner[k] + 1) % 4;
                m_owner[k] = -1;
            end else begin
                m_held[k]++;
            end
        end else begin
            m_exp[k] = 0;
            found = -1;
            for (int off = 0; off < 4; off++)
                if (found < 0 && r[(m_ptr[k] + off) % 4]) found = (m_ptr[k] + off) % 4;
            if (found >= 0) begin
                m_owner[k] = found; m_last[k] = found; m_held[k] = 1;
            end
        end
    endtask

    function automatic logic [7:0] model_vec(input int k);
        logic [3:0] g;
        g = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'd0;
        return {g, 2'(m_last[k]), (m_owner[k] >= 0), (m_exp[k] != 0)};
    endfunction

    // Called at a negedge; drives inputs, advances one edge, checks at the next negedge.
    task automatic cycle(input string tag, input logic [3:0] ra, input logic rsta,
                         input logic [3:0] rb, input logic rstb);
        req_a = ra; reset_a = rsta; req_b = rb; reset_b = rstb;
        @(posedge clk);
        model_step(0, ra, rsta);
        model_step(1, rb, rstb);
        exp_q.push_back(model_vec(0));
        exp_q.push_back(model_vec(1));
        @(negedge clk);
        check({tag, "_a"}, {gnt_a, gnt_id_a, busy_a, expired_a}, exp_q.pop_front());
        check({tag, "_b"}, {gnt_b, gnt_id_b, busy_b, expired_b}, exp_q.pop_front());
    endtask

    task automatic reset_both();
        cycle("reset", 4'd0, 1'b1, 4'd0, 1'b1);
        cycle("reset", 4'd0, 1'b1, 4'd0, 1'b1);
    endtask

    initial begin
        int n_exp;
        int n_starts;
        logic [3:0] prev_g;
        logic [3:0] ra, rb;
        logic [3:0] order[5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_last[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_exp[k] = 0;
        end
        req_a = 4'd0; req_b = 4'd0; reset_a = 1'b1; reset_b = 1'b1;
        @(negedge clk);
        reset_both();
        check("reset_state", {gnt_a, gnt_id_a, busy_a, expired_a}, 8'h00);

        // Single requester holds for three cycles, then releases.
        for (int i = 0; i < 3; i++) cycle("single", 4'b0001, 1'b0, 4'd0, 1'b0);
        check("single_gnt", {4'd0, gnt_a}, 8'h01);
        cycle("single", 4'b0000, 1'b0, 4'd0, 1'b0);
        check("single_gap", {gnt_a, busy_a, expired_a}, 6'b0);
        cycle("single", 4'b0000, 1'b0, 4'd0, 1'b0);
        cycle("single", 4'b0000, 1'b0, 4'd0, 1'b0);

        // All requesting: rotation with hold-limit expiry in every gap.
        reset_both();
        n_exp = 0; n_starts = 0; prev_g = 4'd0;
        for (int i = 0; i < 21; i++) begin
            cycle("rotate", 4'b1111, 1'b0, 4'd0, 1'b0);
            if (expired_a) n_exp++;
            if (gnt_a != 4'd0 && prev_g == 4'd0) begin
                if (n_starts < 5) check("rotate_order", {4'd0, gnt_a}, {4'd0, order[n_starts]});
                n_starts++;
            end
            prev_g = gnt_a;
        end
        check("rotate_expiries", 8'(n_exp), 8'd4);
        check("rotate_starts", 8'(n_starts), 8'd5);

        // Owner 0 releases with 0101 pending: requester 1 is skipped.
        reset_both();
        cycle("skip", 4'b0101, 1'b0, 4'd0, 1'b0);
        check("skip_owner", {4'd0, gnt_a}, 8'h01);
        cycle("skip", 4'b0101, 1'b0, 4'd0, 1'b0);
        cycle("skip", 4'b0100, 1'b0, 4'd0, 1'b0);
        check("skip_gap", {4'd0, gnt_a}, 8'h00);
        cycle("skip", 4'b0100, 1'b0, 4'd0, 1'b0);
        check("skip_next", {4'd0, gnt_a}, 8'h04);

        // Release on the limit cycle is not an expiry.
        reset_both();
        for (int i = 0; i < 4; i++) cycle("edge_rel", 4'b0001, 1'b0, 4'd0, 1'b0);
        cycle("edge_rel", 4'b0000, 1'b0, 4'd0, 1'b0);
        check("edge_rel_exp", {7'd0, expired_a}, 8'h00);
        check("edge_rel_gnt", {4'd0, gnt_a}, 8'h00);

        // Reset mid-grant to requester 2, then arbitration restarts from ptr 0.
        reset_both();
        cycle("mid_rst", 4'b0100, 1'b0, 4'd0, 1'b0);
        cycle("mid_rst", 4'b0100, 1'b0, 4'd0, 1'b0);
        check("mid_rst_own", {4'd0, gnt_a}, 8'h04);
        cycle("mid_rst", 4'b1100, 1'b1, 4'd0, 1'b0);
        check("mid_rst_drop", {gnt_a, busy_a, expired_a, 2'b00}, 8'h00);
        cycle("mid_rst", 4'b1100, 1'b0, 4'd0, 1'b0);
        check("mid_rst_next", {4'd0, gnt_a}, 8'h04);

        // Single-cycle grants on instance b.
        reset_both();
        for (int i = 0; i < 8; i++) begin
            cycle("hold1", 4'd0, 1'b0, 4'b0011, 1'b0);
            case (i % 4)
                0: check("hold1_g0", {4'd0, gnt_b}, 8'h01);
                2: check("hold1_g1", {4'd0, gnt_b}, 8'h02);
                default: check("hold1_gap", {3'd0, gnt_b, expired_b}, 8'h01);
            endcase
        end

        // Randomized traffic with sticky requests and rare resets.
        ra = 4'd0; rb = 4'd0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rb = 4'($urandom_range(0, 15));
            cycle("random", ra, ($urandom_range(0, 39) == 0), rb, ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_fsm.md
RR_ARBITER_FSM -- requirements
Module: rr_arbiter_fsm

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum consecutive grant cycles per owner; legal range 1..256.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: request lines, one per requester 0..3, level-sensitive.
REQ-005 The block SHALL have port gnt, output, 4 bits: registered grant, one-hot or all-zero.
REQ-006 The block SHALL have port gnt_id, output, 2 bits: registered binary index of the current owner; holds the last owner when gnt is all-zero.
REQ-007 The block SHALL have port busy, output, 1 bit: high exactly while state is GRANT.
REQ-008 The block SHALL have port expired, output, 1 bit: one-cycle pulse marking a grant revoked by hold limit.

Function
REQ-009 The state machine SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-010 The block SHALL hold a 2-bit priority pointer ptr; the winner SHALL be the first requester with req set, searching ptr, ptr+1, ptr+2, ptr+3, all mod 4.
REQ-011 In IDLE with req nonzero at a clock edge, the block SHALL enter GRANT, load gnt/gnt_id with the winner and clear hold_cnt to 0; gnt is visible in the cycle after that edge (1-cycle latency).
REQ-012 In IDLE with req = 0, the block SHALL remain in IDLE with gnt = 0.
REQ-013 In GRANT, hold_cnt SHALL increment by 1 each cycle; its width SHALL cover 0..MAX_HOLD-1 with no wrap.
REQ-014 In GRANT, if req[gnt_id] = 0 at an edge, the block SHALL enter GAP, clear gnt and set ptr = gnt_id+1 mod 4; expired stays 0.
REQ-015 In GRANT, if req[gnt_id] = 1 and hold_cnt = MAX_HOLD-1 at an edge, the block SHALL enter GAP, clear gnt, set ptr = gnt_id+1 mod 4 and assert expired for the GAP cycle only.
REQ-016 If the owner drops req on the same edge the hold limit is reached, the block SHALL treat it as a release (REQ-014): expired = 0.
REQ-017 A grant SHALL therefore last at most MAX_HOLD cycles; MAX_HOLD = 1 gives single-cycle grants.
REQ-018 GAP SHALL last exactly one cycle with gnt = 0 and busy = 0; at its end, a nonzero req SHALL arbitrate per REQ-010 using the updated ptr and enter GRANT, otherwise the block SHALL enter IDLE.
REQ-019 Requests that rise or fall during GRANT from non-owners SHALL NOT affect the current grant.
REQ-020 gnt SHALL never have more than one bit set; gnt and busy SHALL change only at clock edges.
REQ-021 An unreachable state encoding SHALL return to IDLE on the next edge with gnt = 0.

Reset
REQ-022 With reset high at an edge, the block SHALL force state = IDLE, gnt = 0000, gnt_id = 00, ptr = 00, hold_cnt = 0, busy = 0 and expired = 0, overriding any other transition.
REQ-023 Reset asserted mid-grant SHALL drop gnt at the next edge without a GAP cycle or expired pulse.
REQ-024 After reset deasserts, arbitration SHALL start from ptr = 0.

Verification (MAX_HOLD = 4 unless stated)
REQ-025 The bench SHALL cover: reset, then req = 0001 for 3 cycles, then 0000 -> gnt = 0001 for cycles 2..4, then GAP with gnt = 0000 and expired = 0, then IDLE.
REQ-026 The bench SHALL cover: req = 1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001; each grant lasts 4 cycles, separated by a 1-cycle gap, with expired = 1 in every gap.
REQ-027 The bench SHALL cover: requester 0 owns, req = 0101, then req[0] drops -> after GAP, gnt = 0100 (requester 1 skipped), ptr = 1 before the search.
REQ-028 The bench SHALL cover: owner drops req on the 4th grant cycle -> expired = 0 in the following gap.
REQ-029 The bench SHALL cover: reset pulsed during the 2nd cycle of grant to requester 2 -> next cycle gnt = 0000, busy = 0; with req = 1100 the next grant is 0100 because ptr = 0.
REQ-030 The bench SHALL cover: MAX_HOLD = 1 with req = 0011 held -> gnt alternates 0001, 0000, 0010, 0000, with expired = 1 in each gap.
